adc_sample_sequencer: RTL

- Controls the dual-AD7264 SPI connector and drives its CPU-side control inputs in place of NIOS.
- Generates a fixed sample period and loads the configuration word into each serializer.
- Frames each conversion with ss, waits for the connector's cycle-complete flag, then latches all four 14-bit channel results.
- Presents the four results to NIOS/FIFO logic as one valid-qualified sample set, with overrun and timeout status.

---
 rtl/adc_sample_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_sequencer.sv
// Drives the dual-AD7264 SPI connector in place of NIOS: periodic trigger, serializer load, ss framing, result capture.
// sample_valid pulses one cycle after CAPTURE; no backpressure, a trigger while busy is dropped and flagged as overrun.
module adc_sample_sequencer #(
   parameter int PERIOD       = 400,
   parameter int SS_GAP       = 4,
   parameter int LOAD_TIMEOUT = 16,
   parameter int XFER_TIMEOUT = 48,
   parameter bit SPI_CPOL     = 1'b1,
   parameter bit SPI_CPHA     = 1'b0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic [15:0] cfg_word,
   output logic        CPOL,
   output logic        CPHA,
   output logic        ss,
   output logic        masterSaysLoad1,
   output logic        masterSaysLoad2,
   output logic [15:0] dataOutOfMaster1,
   output logic [15:0] dataOutOfMaster2,
   input  logic        loadedData1,
   input  logic        loadedData2,
   input  logic        finishedCycling,
   input  logic [13:0] dataIntoMaster1A,
   input  logic [13:0] dataIntoMaster1B,
   input  logic [13:0] dataIntoMaster2A,
   input  logic [13:0] dataIntoMaster2B,
   output logic [13:0] sample1A,
   output logic [13:0] sample1B,
   output logic [13:0] sample2A,
   output logic [13:0] sample2B,
   output logic        sample_valid,
   output logic        overrun,
   output logic        timeout_err,
   output logic        busy,
   input  logic        clear_status
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int GW = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, XFER, CAPTURE, GAP} state_t;

   state_t         state;
   logic [PW-1:0]  periodCnt;
   logic [7:0]     timeoutCnt;
   logic [7:0]     timeoutNext;
   logic [GW-1:0]  gapCnt;

   logic trigger;
   logic loadedBoth;
   logic loadExpired;
   logic xferExpired;
   logic overrunSet;
   logic timeoutSet;

   assign CPOL = SPI_CPOL;
   assign CPHA = SPI_CPHA;

   assign trigger     = enable && (periodCnt == PW'(PERIOD - 1));
   assign loadedBoth  = loadedData1 && loadedData2;
   assign loadExpired = (timeoutCnt >= 8'(LOAD_TIMEOUT - 1));
   assign xferExpired = (timeoutCnt >= 8'(XFER_TIMEOUT - 1));
   assign timeoutNext = (timeoutCnt == 8'hFF) ? timeoutCnt : timeoutCnt + 8'd1;

   // Completion wins over an expiring timeout in the same cycle.
   assign overrunSet = trigger && (state != IDLE);
   assign timeoutSet = ((state == LOAD) && !loadedBoth && loadExpired) ||
                       ((state == XFER) && !finishedCycling && xferExpired);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         periodCnt <= '0;
      end else if (!enable) begin
         periodCnt <= '0;
      end else if (periodCnt == PW'(PERIOD - 1)) begin
         periodCnt <= '0;
      end else begin
         periodCnt <= periodCnt + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= IDLE;
         ss               <= 1'b1;
         masterSaysLoad1  <= 1'b0;
         masterSaysLoad2  <= 1'b0;
         dataOutOfMaster1 <= '0;
         dataOutOfMaster2 <= '0;
         sample1A         <= '0;
         sample1B         <= '0;
         sample2A         <= '0;
         sample2B         <= '0;
         sample_valid     <= 1'b0;
         busy             <= 1'b0;
         timeoutCnt       <= '0;
         gapCnt           <= '0;
      end else begin
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  dataOutOfMaster1 <= cfg_word;
                  dataOutOfMaster2 <= cfg_word;
                  masterSaysLoad1  <= 1'b1;
                  masterSaysLoad2  <= 1'b1;
                  timeoutCnt       <= '0;
                  busy             <= 1'b1;
                  state            <= LOAD;
               end
            end
            LOAD: begin
               timeoutCnt <= timeoutNext;
               if (loadedBoth) begin
                  masterSaysLoad1 <= 1'b0;
                  masterSaysLoad2 <= 1'b0;
                  ss              <= 1'b0;
                  timeoutCnt      <= '0;
                  state           <= XFER;
               end else if (loadExpired) begin
                  masterSaysLoad1 <= 1'b0;
                  masterSaysLoad2 <= 1'b0;
                  gapCnt          <= '0;
                  state           <= GAP;
               end
            end
            XFER: begin
               timeoutCnt <= timeoutNext;
               if (finishedCycling) begin
                  state <= CAPTURE;
               end else if (xferExpired) begin
                  ss     <= 1'b1;
                  gapCnt <= '0;
                  state  <= GAP;
               end
            end
            CAPTURE: begin
               // ss is still low here so the connector holds its terminal count and the data is stable.
               sample1A     <= dataIntoMaster1A;
               sample1B     <= dataIntoMaster1B;
               sample2A     <= dataIntoMaster2A;
               sample2B     <= dataIntoMaster2B;
               sample_valid <= 1'b1;
               ss           <= 1'b1;
               gapCnt       <= '0;
               state        <= GAP;
            end
            GAP: begin
               if (gapCnt == GW'(SS_GAP - 1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gapCnt <= gapCnt + GW'(1);
               end
            end
            default: begin
               ss              <= 1'b1;
               masterSaysLoad1 <= 1'b0;
               masterSaysLoad2 <= 1'b0;
               busy            <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

   // A set in the same cycle as clear_status wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (overrunSet) begin
            overrun <= 1'b1;
         end else if (clear_status) begin
            overrun <= 1'b0;
         end
         if (timeoutSet) begin
            timeout_err <= 1'b1;
         end else if (clear_status) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule
